// File: rtl/mem_sram_resp.sv
// Memory-bus responder backed by a 64-bit wide SRAM array with fixed wait states.
// Define MEM_SRAM_RESP_ERR_EN to enable misalignment and range checks (SLVERR).
module mem_sram_resp #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_sram_resp_valid_i,
  input  logic        mem_sram_resp_req_i,
  input  logic [63:0] mem_sram_resp_addr_i,
  input  logic [1:0]  mem_sram_resp_size_i,
  input  logic [63:0] mem_sram_resp_data_write_i,
  output logic        mem_sram_resp_ready_o,
  output logic [63:0] mem_sram_resp_data_read_o,
  output logic [1:0]  mem_sram_resp_resp_o,
  output logic        mem_sram_resp_busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IW = AW + 3;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        req_q;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic [63:0] wdat_q;

  logic [63:0] mem [DEPTH_WORDS];

  logic        a_req;
  logic [63:0] a_addr;
  logic [1:0]  a_size;
  logic [63:0] a_wdat;
  logic [AW-1:0] idx;
  logic [5:0]  sh;
  logic [7:0]  be;
  logic [63:0] bmask;
  logic [63:0] szm;
  logic [63:0] rd_val;
  logic [63:0] wr_word;
  logic        err;

  // In IDLE the request is still on the inputs; afterwards use the latched copy.
  always_comb begin
    a_req  = req_q;
    a_addr = addr_q;
    a_size = size_q;
    a_wdat = wdat_q;
    if (state == IDLE) begin
      a_req  = mem_sram_resp_req_i;
      a_addr = mem_sram_resp_addr_i;
      a_size = mem_sram_resp_size_i;
      a_wdat = mem_sram_resp_data_write_i;
    end
  end

  assign idx = AW'(a_addr[IW-1:3] - BASE_ADDR[IW-1:3]);
  assign sh  = {a_addr[2:0], 3'b000};

  always_comb begin
    be  = 8'h00;
    szm = '0;
    unique case (a_size)
      2'b00: begin be = 8'h01; szm = 64'hFF; end
      2'b01: begin be = 8'h03; szm = 64'hFFFF; end
      2'b10: begin be = 8'h0F; szm = 64'hFFFF_FFFF; end
      default: begin be = 8'hFF; szm = '1; end
    endcase
    be = be << a_addr[2:0];
  end

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++)
      bmask[i*8 +: 8] = {8{be[i]}};
  end

  assign rd_val  = (mem[idx] >> sh) & szm;
  assign wr_word = (mem[idx] & ~bmask) | ((a_wdat << sh) & bmask);

`ifdef MEM_SRAM_RESP_ERR_EN
  localparam logic [63:0] LIMIT = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;
  logic [2:0] amask;
  always_comb begin
    amask = 3'b000;
    unique case (a_size)
      2'b00: amask = 3'b000;
      2'b01: amask = 3'b001;
      2'b10: amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end
  assign err = (|(a_addr[2:0] & amask)) ||
               (a_addr < BASE_ADDR) ||
               (a_addr >= LIMIT);
`else
  logic unused_hi;
  assign unused_hi = ^a_addr[63:IW];
  assign err = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        if (mem_sram_resp_valid_i) begin
          cnt_nxt = WC;
          nxt     = (WC == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) nxt = RESP;
      end
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      wdat_q <= '0;
      mem_sram_resp_ready_o     <= 1'b0;
      mem_sram_resp_data_read_o <= '0;
      mem_sram_resp_resp_o      <= 2'b00;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && mem_sram_resp_valid_i) begin
        req_q  <= mem_sram_resp_req_i;
        addr_q <= mem_sram_resp_addr_i;
        size_q <= mem_sram_resp_size_i;
        wdat_q <= mem_sram_resp_data_write_i;
      end
      mem_sram_resp_ready_o <= (nxt == RESP);
      mem_sram_resp_data_read_o <=
        (nxt == RESP && !a_req && !err) ? rd_val : '0;
      mem_sram_resp_resp_o <=
        (nxt == RESP && err) ? 2'b10 : 2'b00;
    end
  end

  // Stores land on the edge that ends RESP; reset forces IDLE first.
  always_ff @(posedge clk) begin
    if (state == RESP && a_req && !err)
      mem[idx] <= wr_word;
  end

  assign mem_sram_resp_busy_o = (state != IDLE);

endmodule

// File: tb/tb_mem_sram_resp.sv
// Scoreboard bench for mem_sram_resp: a 2-wait-state instance and a
// zero-wait instance, driven with hand-computed directed vectors.
module tb_mem_sram_resp;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;
`ifdef MEM_SRAM_RESP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        a_v = 0, a_req = 0, a_rdy, a_busy;
  logic [63:0] a_addr = 0, a_wd = 0, a_rd;
  logic [1:0]  a_sz = 0, a_resp;
  logic        b_v = 0, b_req = 0, b_rdy, b_busy;
  logic [63:0] b_addr = 0, b_wd = 0, b_rd;
  logic [1:0]  b_sz = 0, b_resp;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_sram_resp #(.WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst),
    .mem_sram_resp_valid_i(a_v),
    .mem_sram_resp_req_i(a_req),
    .mem_sram_resp_addr_i(a_addr),
    .mem_sram_resp_size_i(a_sz),
    .mem_sram_resp_data_write_i(a_wd),
    .mem_sram_resp_ready_o(a_rdy),
    .mem_sram_resp_data_read_o(a_rd),
    .mem_sram_resp_resp_o(a_resp),
    .mem_sram_resp_busy_o(a_busy)
  );

  mem_sram_resp #(.WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst),
    .mem_sram_resp_valid_i(b_v),
    .mem_sram_resp_req_i(b_req),
    .mem_sram_resp_addr_i(b_addr),
    .mem_sram_resp_size_i(b_sz),
    .mem_sram_resp_data_write_i(b_wd),
    .mem_sram_resp_ready_o(b_rdy),
    .mem_sram_resp_data_read_o(b_rd),
    .mem_sram_resp_resp_o(b_resp),
    .mem_sram_resp_busy_o(b_busy)
  );

  task automatic check(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rdy) begin
      if (qa.size() == 0) begin
        check("a_unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_data", a_rd, e.d);
        check("a_resp", {62'd0, a_resp}, {62'd0, e.r});
      end
    end
  end

  always @(negedge clk) begin
    if (b_rdy) begin
      if (qb.size() == 0) begin
        check("b_unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_data", b_rd, e.d);
        check("b_resp", {62'd0, b_resp}, {62'd0, e.r});
        check("b_busy", {63'd0, b_busy}, 64'd1);
      end
    end
  end

  task automatic issue(input bit sel, input logic w,
                       input logic [63:0] addr, input logic [1:0] sz,
                       input logic [63:0] wd, input logic [63:0] ed,
                       input logic [1:0] er, input bit tog);
    int lat;
    @(negedge clk);
    if (!sel) begin
      a_v = 1; a_req = w; a_addr = addr; a_sz = sz; a_wd = wd;
      qa.push_back('{d: ed, r: er});
    end else begin
      b_v = 1; b_req = w; b_addr = addr; b_sz = sz; b_wd = wd;
      qb.push_back('{d: ed, r: er});
    end
    @(negedge clk);
    a_v = 0;
    b_v = 0;
    if (tog) begin
      a_addr = B + 64'h20;
      a_wd   = 64'h0;
    end
    lat = 1;
    while (!(sel ? b_rdy : a_rdy) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check(sel ? "b_latency" : "a_latency", 64'(lat), sel ? 64'd1 : 64'd3);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    logic [63:0] w0;
    int guard;

    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, a_rdy}, 64'd0);
    check("rst_data", a_rd, 64'd0);
    check("rst_resp", {62'd0, a_resp}, 64'd0);
    check("rst_busy", {63'd0, a_busy}, 64'd0);
    rst = 1'b1;

    issue(0, 1, B + 64'h8, 2'b11, 64'h1122334455667788, 0, 0, 0);
    issue(0, 0, B + 64'h8, 2'b11, 0, 64'h1122334455667788, 0, 0);
    issue(0, 1, B + 64'hD, 2'b00, 64'hAB, 0, 0, 0);
    issue(0, 0, B + 64'h8, 2'b11, 0, 64'h1122AB4455667788, 0, 0);
    issue(0, 0, B + 64'hC, 2'b01, 0, 64'h000000000000AB44, 0, 0);
    issue(0, 0, B + 64'hC, 2'b10, 0, 64'h000000001122AB44, 0, 0);
    issue(0, 0, B + 64'hF, 2'b00, 0, 64'h11, 0, 0);

    issue(0, 1, B + 64'h10, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    issue(0, 1, B + 64'h14, 2'b10, 64'h1234_5678_DEAD_BEEF, 0, 0, 0);
    issue(0, 0, B + 64'h10, 2'b11, 0, 64'hDEADBEEF_FFFFFFFF, 0, 0);

    issue(0, 1, B, 2'b11, 64'h0123456789ABCDEF, 0, 0, 0);
    issue(0, 1, B + 64'hFF8, 2'b11, 64'h5555AAAA0F0FF0F0, 0, 0, 0);
    issue(0, 1, B + 64'h2, 2'b10, 64'hA5A5A5A5, 0, ERR ? 2'b10 : 2'b00, 0);
    w0 = ERR ? 64'h0123456789ABCDEF : 64'h0123A5A5A5A5CDEF;
    issue(0, 0, B, 2'b11, 0, w0, 0, 0);
    issue(0, 0, B - 64'h8, 2'b11, 0,
          ERR ? 64'h0 : 64'h5555AAAA0F0FF0F0, ERR ? 2'b10 : 2'b00, 0);
    issue(0, 0, B + 64'h1000, 2'b11, 0,
          ERR ? 64'h0 : w0, ERR ? 2'b10 : 2'b00, 0);

    @(negedge clk);
    a_v = 1; a_req = 1; a_addr = B + 64'h8; a_sz = 2'b11; a_wd = 64'hDEAD;
    @(negedge clk);
    a_v = 0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", {63'd0, a_rdy}, 64'd0);
    check("mid_rst_data", a_rd, 64'd0);
    check("mid_rst_resp", {62'd0, a_resp}, 64'd0);
    check("mid_rst_busy", {63'd0, a_busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    issue(0, 0, B + 64'h8, 2'b11, 0, 64'h1122AB4455667788, 0, 0);
    issue(0, 0, B + 64'hD, 2'b01, 0,
          ERR ? 64'h0 : 64'h22AB, ERR ? 2'b10 : 2'b00, 0);

    issue(0, 1, B + 64'h20, 2'b11, 64'h1, 0, 0, 0);
    issue(0, 1, B + 64'h18, 2'b11, 64'hFEED_FACE, 0, 0, 1);
    issue(0, 0, B + 64'h18, 2'b11, 0, 64'hFEED_FACE, 0, 0);
    issue(0, 0, B + 64'h20, 2'b11, 0, 64'h1, 0, 0);

    issue(1, 1, B, 2'b11, 64'h77, 0, 0, 0);
    @(negedge clk);
    b_v = 1; b_req = 0; b_addr = B; b_sz = 2'b11;
    repeat (4) qb.push_back('{d: 64'h77, r: 2'b00});
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = b_rdy;
    end
    b_v = 0;
    check("b_ready_pattern", {56'd0, pat}, 64'h55);

    guard = 0;
    while ((qa.size() != 0 || qb.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_qa", 64'(qa.size()), 64'd0);
    check("drain_qb", 64'(qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sram_resp.md
# mem_sram_resp

Responder end of the core's simple memory bus (valid/ready/req/addr/size/data/resp): accepts one load or store at a time from the load/store path, services it from an internal 64-bit-wide SRAM array after a fixed number of wait states, and returns ready, read data and a response code. Sits where the data-bus distributor's memory-side port lands, as on-chip scratchpad memory and as a bus responder model for pipeline bring-up.

## Interface
Parameters:
- DEPTH_WORDS, 512, number of 64-bit words in the array; power of two.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and ready; 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- mem_sram_resp_valid_i  in  1  request valid from initiator.
- mem_sram_resp_req_i  in  1  1 = write, 0 = read.
- mem_sram_resp_addr_i  in  64  byte address.
- mem_sram_resp_size_i  in  2  00 byte, 01 half, 10 word, 11 double.
- mem_sram_resp_data_write_i  in  64  store data, right-aligned.
- mem_sram_resp_ready_o  out  1  one-cycle completion strobe.
- mem_sram_resp_data_read_o  out  64  load data, right-aligned and zero-extended; valid only with ready.
- mem_sram_resp_resp_o  out  2  00 OKAY, 10 SLVERR; valid only with ready.
- mem_sram_resp_busy_o  out  1  high from acceptance through the ready cycle.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on valid_i=1, latch req, addr, size and data_write, load the wait counter with WAIT_CYCLES, and assert busy. Go to WAIT, or to RESP if WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP.
- RESP: assert ready_o for exactly one cycle and return to IDLE.
- A store commits to the array on the clock edge that ends RESP. A load drives data_read_o during RESP.
- Word index = (addr - BASE_ADDR)[3+log2(DEPTH_WORDS)-1:3]. Byte lane = addr[2:0].
- Store: the low 8/16/32/64 bits of the latched data are shifted to lane addr[2:0], with a byte-enable mask derived from size and lane. Bytes outside the mask are unchanged.
- Load: the selected bytes are shifted down to bit 0, and the upper bits are zeroed. Sign extension belongs to the initiator.
- Latched request fields are held stable internally. Changes on the inputs after acceptance are ignored.
- The initiator must deassert valid_i on the cycle after ready_o. A valid_i sampled high in IDLE is always treated as a new request, so back-to-back requests are legal with one IDLE cycle between them.
- The array is not reset. Its contents are undefined until written.

## Timing
- Reset values: ready_o=0, data_read_o=0, resp_o=00, busy_o=0, FSM=IDLE, counter=0.
- Latency: ready_o is asserted WAIT_CYCLES+1 cycles after the edge at which valid_i is sampled in IDLE. Minimum latency is 1 (WAIT_CYCLES=0).
- Throughput: one request per WAIT_CYCLES+2 cycles.
- data_read_o and resp_o are registered, and return to 0 in every cycle that is not RESP.
- Reset asserted mid-request (WAIT or RESP): the FSM returns to IDLE immediately, no ready_o is issued, and a pending store is not committed.
- A RESP cycle coincident with valid_i=1 does not accept a new request.

## Configuration
- MEM_SRAM_RESP_ERR_EN defined: error checks are enabled. A request is an error if it is misaligned (addr not a multiple of 2^size) or out of range (addr < BASE_ADDR or addr >= BASE_ADDR + 8·DEPTH_WORDS).
  - An erroring request still takes full latency and returns resp_o=10 with data_read_o=0.
  - An erroring store is dropped and the array is unchanged.
- MEM_SRAM_RESP_ERR_EN undefined: resp_o is always 00. Index bits above the array size are ignored, so addresses wrap. Lanes are taken from addr[2:0] as given, and bytes that would cross the 8-byte boundary are discarded.

## Test plan
- Double store then load: write 64'h1122334455667788 at BASE_ADDR+8, WAIT_CYCLES=2, then read size 11 -> each ready_o arrives 3 cycles after valid_i; read data 64'h1122334455667788, resp 00.
- Sub-word lanes: write byte 8'hAB at BASE_ADDR+0xD over a word that previously read 64'h1122334455667788 -> double read returns 64'h1122AB4455667788. Half read at +0xC returns 64'h000000000000AB44.
- Zero wait states: WAIT_CYCLES=0, back-to-back reads held valid as legal -> ready_o every 2nd cycle, busy_o high on each accepted request.
- Errors with MEM_SRAM_RESP_ERR_EN: word write at BASE_ADDR+2 -> resp 10 and memory unchanged. Read at BASE_ADDR-8 -> resp 10, data 0. Without the macro, the same read returns resp 00 with wrapped-index data.
- Reset mid-request: assert rst low during WAIT of a store of 64'hDEAD -> no ready_o, all outputs at reset values, and a later read of that address shows the old data.
- Input change after accept: toggle addr_i and data_write_i during WAIT -> the store commits the originally latched address and data.
